// File: rtl/reg_file32_pkg.sv
// Shared sizing and constants for the 32 x 32-bit register file.
package reg_file32_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned REG_COUNT = 32;

    localparam logic [4:0]  ZERO_REG  = 5'd0;
    localparam logic [31:0] RESET_VAL = 32'h0000_0000;

endpackage

// File: rtl/reg_file32_reg32_en.sv
// Single storage word: synchronous active-high reset plus load enable.
module reg32_en #(
    parameter int unsigned DATA_W  = 32,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_file32.sv
// Two-read, one-write register file; index 0 has no storage and reads zero.
module reg_file32 #(
    parameter int unsigned DATA_W = reg_file32_pkg::DATA_W,
    parameter int unsigned ADDR_W = reg_file32_pkg::ADDR_W,
    parameter int unsigned BYPASS = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    import reg_file32_pkg::*;

    localparam int unsigned NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] w_regs [NREGS];
    logic              w_wr_live;
    logic              w_hit1;
    logic              w_hit2;

    // A write only reaches storage when not in reset and not aimed at r0.
    assign w_wr_live = reg_write & ~reset & (write_reg != ZERO_IDX);

    assign w_regs[0] = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_reg
        logic w_en;

        assign w_en = w_wr_live & (write_reg == ADDR_W'(i));

        reg32_en #(
            .DATA_W  (DATA_W),
            .RST_VAL (DATA_W'(RESET_VAL))
        ) u_reg (
            .i_clk (clk),
            .i_rst (reset),
            .i_en  (w_en),
            .i_d   (write_data),
            .o_q   (w_regs[i])
        );
    end

    always_comb begin
        w_hit1 = (BYPASS != 0) && w_wr_live && (write_reg == read_reg1);
        w_hit2 = (BYPASS != 0) && w_wr_live && (write_reg == read_reg2);
        read_data1 = w_hit1 ? write_data : w_regs[read_reg1];
        read_data2 = w_hit2 ? write_data : w_regs[read_reg2];
    end

endmodule

// File: tb/tb_reg_file32.sv
// Self-checking bench: drives a BYPASS=0 and a BYPASS=1 instance in lockstep.
module tb_reg_file32;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] rd1_b0, rd2_b0, rd1_b1, rd2_b1;

    logic [31:0] model [32];
    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    reg_file32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_b0 (
        .clk(clk), .reset(rst), .reg_write(we), .write_reg(wr), .write_data(wd),
        .read_reg1(rr1), .read_reg2(rr2), .read_data1(rd1_b0), .read_data2(rd2_b0)
    );

    reg_file32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_b1 (
        .clk(clk), .reset(rst), .reg_write(we), .write_reg(wr), .write_data(wd),
        .read_reg1(rr1), .read_reg2(rr2), .read_data1(rd1_b1), .read_data2(rd2_b1)
    );

    // Reference read: r0 is zero; bypass returns the in-flight write on a live collision.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && we && !rst && wr == a) return wd;
        return model[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && wr != 5'd0) begin
            model[wr] = wd;
        end
        @(negedge clk);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        rst = 1'b0; we = 1'b1; wr = a; wd = d;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; wr = 5'd0; wd = 32'h0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rr1 = 5'(i); rr2 = 5'(31 - i);
            #1;
            checks += 2;
            if (rd1_b0 !== 32'h0) begin
                failures++; $display("FAIL reset_rd1 r%0d got=%h exp=%h", i, rd1_b0, 32'h0);
            end
            if (rd2_b1 !== 32'h0) begin
                failures++; $display("FAIL reset_rd2 r%0d got=%h exp=%h", 31 - i, rd2_b1, 32'h0);
            end
        end
    endtask

    task automatic test_reset_clear();
        do_write(5'd5, 32'hDEAD_BEEF);
        rr1 = 5'd5; rr2 = 5'd5; #1;
        checks++;
        if (rd1_b0 !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL clear_pre got=%h exp=%h", rd1_b0, 32'hDEAD_BEEF);
        end
        rst = 1'b1; tick(); rst = 1'b0; #1;
        checks += 2;
        if (rd1_b0 !== 32'h0) begin
            failures++; $display("FAIL clear_rd1 got=%h exp=%h", rd1_b0, 32'h0);
        end
        if (rd2_b1 !== 32'h0) begin
            failures++; $display("FAIL clear_rd2 got=%h exp=%h", rd2_b1, 32'h0);
        end
    endtask

    task automatic test_write_read();
        do_write(5'd7, 32'h1234_5678);
        rr1 = 5'd7; rr2 = 5'd7; #1;
        checks += 2;
        if (rd1_b0 !== 32'h1234_5678) begin
            failures++; $display("FAIL wr_rd1 got=%h exp=%h", rd1_b0, 32'h1234_5678);
        end
        if (rd2_b0 !== 32'h1234_5678) begin
            failures++; $display("FAIL wr_rd2 got=%h exp=%h", rd2_b0, 32'h1234_5678);
        end
    endtask

    task automatic test_r0();
        do_write(5'd1, 32'h0BAD_F00D);
        rst = 1'b0; we = 1'b1; wr = 5'd0; wd = 32'hFFFF_FFFF;
        rr1 = 5'd0; rr2 = 5'd1; #1;
        checks++;
        if (rd1_b1 !== 32'h0) begin
            failures++; $display("FAIL r0_bypass got=%h exp=%h", rd1_b1, 32'h0);
        end
        tick(); we = 1'b0; #1;
        checks += 3;
        if (rd1_b0 !== 32'h0) begin
            failures++; $display("FAIL r0_b0 got=%h exp=%h", rd1_b0, 32'h0);
        end
        if (rd1_b1 !== 32'h0) begin
            failures++; $display("FAIL r0_b1 got=%h exp=%h", rd1_b1, 32'h0);
        end
        if (rd2_b0 !== 32'h0BAD_F00D) begin
            failures++; $display("FAIL r0_r1_kept got=%h exp=%h", rd2_b0, 32'h0BAD_F00D);
        end
    endtask

    task automatic test_dual_port();
        do_write(5'd3, 32'h0000_00F0);
        do_write(5'd4, 32'h0000_000F);
        rr1 = 5'd3; rr2 = 5'd4; #1;
        checks += 3;
        if (rd1_b0 !== 32'h0000_00F0) begin
            failures++; $display("FAIL dual_rd1 got=%h exp=%h", rd1_b0, 32'h0000_00F0);
        end
        if (rd2_b0 !== 32'h0000_000F) begin
            failures++; $display("FAIL dual_rd2 got=%h exp=%h", rd2_b0, 32'h0000_000F);
        end
        if ((rd1_b0 | rd2_b0) !== 32'h0000_00FF) begin
            failures++; $display("FAIL dual_or got=%h exp=%h", rd1_b0 | rd2_b0, 32'h0000_00FF);
        end
    endtask

    task automatic test_collision();
        do_write(5'd9, 32'h0000_0001);
        rst = 1'b0; we = 1'b1; wr = 5'd9; wd = 32'h0000_0002;
        rr1 = 5'd9; rr2 = 5'd9; #1;
        checks += 2;
        if (rd1_b0 !== 32'h0000_0001) begin
            failures++; $display("FAIL coll_b0_pre got=%h exp=%h", rd1_b0, 32'h1);
        end
        if (rd2_b1 !== 32'h0000_0002) begin
            failures++; $display("FAIL coll_b1_same got=%h exp=%h", rd2_b1, 32'h2);
        end
        tick(); we = 1'b0; #1;
        checks += 2;
        if (rd1_b0 !== 32'h0000_0002) begin
            failures++; $display("FAIL coll_b0_post got=%h exp=%h", rd1_b0, 32'h2);
        end
        if (rd1_b1 !== 32'h0000_0002) begin
            failures++; $display("FAIL coll_b1_post got=%h exp=%h", rd1_b1, 32'h2);
        end
    endtask

    task automatic test_reset_vs_write();
        do_write(5'd10, 32'h5555_5555);
        rst = 1'b1; we = 1'b1; wr = 5'd10; wd = 32'hAAAA_AAAA;
        rr1 = 5'd10; rr2 = 5'd10; #1;
        checks++;
        if (rd1_b1 !== 32'h5555_5555) begin
            failures++; $display("FAIL rvw_nobypass got=%h exp=%h", rd1_b1, 32'h5555_5555);
        end
        tick(); rst = 1'b0; we = 1'b0; #1;
        checks += 2;
        if (rd1_b0 !== 32'h0) begin
            failures++; $display("FAIL rvw_b0 got=%h exp=%h", rd1_b0, 32'h0);
        end
        if (rd2_b1 !== 32'h0) begin
            failures++; $display("FAIL rvw_b1 got=%h exp=%h", rd2_b1, 32'h0);
        end
    endtask

    task automatic test_random(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            rst = ($urandom_range(0, 39) == 0);
            we  = ($urandom_range(0, 3) != 0);
            wr  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            rr1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            rr2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            #1;
            checks += 4;
            if (rd1_b0 !== exp_rd(rr1, 1'b0)) begin
                failures++; $display("FAIL rand_b0_rd1 k=%0d r%0d got=%h exp=%h", k, rr1, rd1_b0, exp_rd(rr1, 1'b0));
            end
            if (rd2_b0 !== exp_rd(rr2, 1'b0)) begin
                failures++; $display("FAIL rand_b0_rd2 k=%0d r%0d got=%h exp=%h", k, rr2, rd2_b0, exp_rd(rr2, 1'b0));
            end
            if (rd1_b1 !== exp_rd(rr1, 1'b1)) begin
                failures++; $display("FAIL rand_b1_rd1 k=%0d r%0d got=%h exp=%h", k, rr1, rd1_b1, exp_rd(rr1, 1'b1));
            end
            if (rd2_b1 !== exp_rd(rr2, 1'b1)) begin
                failures++; $display("FAIL rand_b1_rd2 k=%0d r%0d got=%h exp=%h", k, rr2, rd2_b1, exp_rd(rr2, 1'b1));
            end
            tick();
        end
        rst = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; wr = '0; wd = '0; rr1 = '0; rr2 = '0;
        for (int i = 0; i < 32; i++) model[i] = 'x;
        @(negedge clk);
        test_reset();
        test_reset_clear();
        test_write_read();
        test_r0();
        test_dual_port();
        test_collision();
        test_reset_vs_write();
        test_random(400);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
